// File: rtl/lcd8080_bus_ctrl.sv
// 8080-style parallel LCD bus master (HX8352-class panels).
// A small request FIFO decouples upstream sequencers from the bus timing.
// A four-state FSM runs each transfer through SETUP, LOW (strobe asserted)
// and RECOVER phases. A single shared 4-bit down-counter times the phases.
// All pad-facing outputs are registered, so the pins never glitch.
module lcd8080_bus_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int SETUP_CYCLES   = 1,
  parameter int WR_LOW_CYCLES  = 1,
  parameter int RD_LOW_CYCLES  = 3,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  // upstream request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rs,
  input  logic                  req_read,
  input  logic [DATA_WIDTH-1:0] req_data,
  // read response and status
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  done,
  // LCD pins
  output logic                  lcd_cs,
  output logic                  lcd_rs,
  output logic                  lcd_wr,
  output logic                  lcd_rd,
  output logic [DATA_WIDTH-1:0] lcd_db_out,
  output logic                  lcd_db_oe,
  input  logic [DATA_WIDTH-1:0] lcd_db_in
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Each phase counter is loaded with (N-1), so a phase lasts exactly N cycles.
  localparam logic [3:0] SETUP_LOAD   = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] WR_LOW_LOAD  = 4'(WR_LOW_CYCLES - 1);
  localparam logic [3:0] RD_LOW_LOAD  = 4'(RD_LOW_CYCLES - 1);
  localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_RECOVER
  } state_t;

  typedef struct packed {
    logic                  read;
    logic                  rs;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // The pointers carry one extra wrap bit, so that full and empty can be
  // told apart without a separate count register.
  // ---------------------------------------------------------------------------
  entry_t          fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]  wr_ptr;
  logic [PTR_W:0]  rd_ptr;
  logic [PTR_W:0]  fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  entry_t          head;

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && req_ready;
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

  // Advance the FIFO pointers on push/pop; a reset discards every queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Write the FIFO storage.
  // NOTE: storage has no reset; an entry is only read after it has been written, and the pointers (which are reset) gate that.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {req_read, req_rs, req_data};
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  state_t                state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic                  cur_read, cur_read_d;
  logic                  lcd_cs_d, lcd_rs_d, lcd_wr_d, lcd_rd_d, lcd_db_oe_d;
  logic [DATA_WIDTH-1:0] lcd_db_out_d;
  logic                  done_d, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_d;

  // Register the FSM state, the phase counter and every pad/response output.
  // NOTE: sequential state uses non-blocking (<=) so that all registers update together at the edge; the combinational block below uses blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cur_read   <= 1'b0;
      lcd_cs     <= 1'b1;
      lcd_rs     <= 1'b0;
      lcd_wr     <= 1'b1;
      lcd_rd     <= 1'b1;
      lcd_db_out <= '0;
      lcd_db_oe  <= 1'b0;
      done       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cur_read   <= cur_read_d;
      lcd_cs     <= lcd_cs_d;
      lcd_rs     <= lcd_rs_d;
      lcd_wr     <= lcd_wr_d;
      lcd_rd     <= lcd_rd_d;
      lcd_db_out <= lcd_db_out_d;
      lcd_db_oe  <= lcd_db_oe_d;
      done       <= done_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
    end
  end

  // Compute the next state, the counter reload and the next pin values for each phase.
  // NOTE: every signal gets a default first (hold or idle value), so no path through the case can infer a latch.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    cur_read_d   = cur_read;
    lcd_cs_d     = lcd_cs;
    lcd_rs_d     = lcd_rs;
    lcd_wr_d     = lcd_wr;
    lcd_rd_d     = lcd_rd;
    lcd_db_out_d = lcd_db_out;
    lcd_db_oe_d  = lcd_db_oe;
    rsp_data_d   = rsp_data;
    done_d       = 1'b0;
    rsp_valid_d  = 1'b0;
    pop          = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          // Launch: select the chip and present RS/data, which then hold until
          // the edge that returns to IDLE.
          pop          = 1'b1;
          state_d      = ST_SETUP;
          cnt_d        = SETUP_LOAD;
          cur_read_d   = head.read;
          lcd_cs_d     = 1'b0;
          lcd_rs_d     = head.rs;
          lcd_db_out_d = head.data;
          lcd_db_oe_d  = !head.read;
        end
      end

      ST_SETUP: begin
        if (cnt == 4'd0) begin
          state_d = ST_LOW;
          if (cur_read) begin
            cnt_d    = RD_LOW_LOAD;
            lcd_rd_d = 1'b0;
          end else begin
            cnt_d    = WR_LOW_LOAD;
            lcd_wr_d = 1'b0;
          end
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end

      ST_LOW: begin
        if (cnt == 4'd0) begin
          // The read data is captured on the same edge that raises lcd_rd.
          state_d  = ST_RECOVER;
          cnt_d    = RECOVER_LOAD;
          lcd_wr_d = 1'b1;
          lcd_rd_d = 1'b1;
          if (cur_read) rsp_data_d = lcd_db_in;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end

      ST_RECOVER: begin
        if (cnt == 4'd0) begin
          state_d     = ST_IDLE;
          lcd_cs_d    = 1'b1;
          lcd_db_oe_d = 1'b0;
          done_d      = 1'b1;
          rsp_valid_d = cur_read;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_lcd8080_bus_ctrl.sv
// Self-checking bench for lcd8080_bus_ctrl.
// The driver pushes an expected transfer record into a scoreboard queue on
// every accepted request. The monitor rebuilds each bus transfer from the pins
// (phase widths, RS, data, OE, strobe kind) and compares it when done pulses.
// A panel model answers reads with the expected word, and only during the
// last LOW cycle.
module tb_lcd8080_bus_ctrl;

  localparam int DW      = 16;
  localparam int DEPTH   = 4;
  localparam int SETUP   = 1;
  localparam int WR_LOW  = 1;
  localparam int RD_LOW  = 3;
  localparam int RECOVER = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rs = 1'b0;
  logic          req_read = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          done;
  logic          lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_db_oe;
  logic [DW-1:0] lcd_db_out;
  logic [DW-1:0] lcd_db_in = '0;

  lcd8080_bus_ctrl #(
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH),
    .SETUP_CYCLES  (SETUP),
    .WR_LOW_CYCLES (WR_LOW),
    .RD_LOW_CYCLES (RD_LOW),
    .RECOVER_CYCLES(RECOVER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_read  (req_read),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .done      (done),
    .lcd_cs    (lcd_cs),
    .lcd_rs    (lcd_rs),
    .lcd_wr    (lcd_wr),
    .lcd_rd    (lcd_rd),
    .lcd_db_out(lcd_db_out),
    .lcd_db_oe (lcd_db_oe),
    .lcd_db_in (lcd_db_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          read;
    logic          rs;
    logic [DW-1:0] data;
    logic [DW-1:0] rdata;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_cmp      = 0;
  int    n_bad      = 0;
  int    done_count = 0;
  int    rsp_count  = 0;
  bit    saw_full   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Present one request and hold it until accepted. hold=1 keeps req_valid
  // high for a following push.
  task automatic push(input logic rd, input logic rs, input logic [DW-1:0] d,
                      input logic [DW-1:0] rdv, input bit hold);
    xfer_t e;
    bit    ok;
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_read  = rd;
    req_rs    = rs;
    req_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      else begin
        saw_full = 1'b1;
        @(negedge clk);
      end
    end
    if (!ok) begin
      check("push_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      e.read  = rd;
      e.rs    = rs;
      e.data  = d;
      e.rdata = rdv;
      exp_q.push_back(e);
      @(posedge clk);
      if (!hold) begin
        #1;
        req_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Panel model: the expected read word appears only during the last LOW cycle.
  int panel_low = 0;
  initial begin : panel
    logic [DW-1:0] want;
    forever begin
      @(negedge clk);
      if (!lcd_rd) panel_low++;
      else panel_low = 0;
      want = (exp_q.size() > 0) ? exp_q[0].rdata : '0;
      if (!lcd_rd && panel_low == RD_LOW) lcd_db_in = want;
      else lcd_db_in = want ^ (DW'($urandom) | DW'(1));
    end
  end

  // Monitor: rebuild each transfer from the pins and score it when done pulses.
  int            m_setup, m_low, m_rec;
  bit            m_wr, m_rd, m_overlap, m_unstable, m_started, m_strobed;
  logic          m_rs, m_oe;
  logic [DW-1:0] m_data;

  task automatic m_clear();
    m_setup = 0; m_low = 0; m_rec = 0;
    m_wr = 0; m_rd = 0; m_overlap = 0; m_unstable = 0; m_started = 0; m_strobed = 0;
  endtask

  initial begin : monitor
    xfer_t e;
    m_clear();
    forever begin
      @(negedge clk);
      if (rst) begin
        m_clear();
        continue;
      end
      if (!lcd_wr && !lcd_rd) m_overlap = 1'b1;
      if (!lcd_cs) begin
        if (!m_started) begin
          m_started = 1'b1;
          m_rs = lcd_rs; m_oe = lcd_db_oe; m_data = lcd_db_out;
        end else if (lcd_rs !== m_rs || lcd_db_oe !== m_oe || lcd_db_out !== m_data) begin
          m_unstable = 1'b1;
        end
        if (!lcd_wr || !lcd_rd) begin
          m_low++;
          m_strobed = 1'b1;
          if (!lcd_wr) m_wr = 1'b1;
          if (!lcd_rd) m_rd = 1'b1;
        end else if (m_strobed) m_rec++;
        else m_setup++;
      end
      if (rsp_valid) rsp_count++;
      if (rsp_valid && !done) check("rsp_valid_without_done", 32'd1, 32'd0);
      if (done) begin
        done_count++;
        if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("cs_high_at_done", lcd_cs, 1'b1);
          check("rs", m_rs, e.rs);
          check("oe", m_oe, !e.read);
          check("pins_stable", m_unstable, 1'b0);
          check("wr_strobe_used", m_wr, !e.read);
          check("rd_strobe_used", m_rd, e.read);
          check("strobe_overlap", m_overlap, 1'b0);
          check("setup_cycles", m_setup, SETUP);
          check("low_cycles", m_low, e.read ? RD_LOW : WR_LOW);
          check("recover_cycles", m_rec, RECOVER);
          check("rsp_valid_at_done", rsp_valid, e.read);
          if (e.read) check("rsp_data", rsp_data, e.rdata);
          else        check("write_data", m_data, e.data);
        end
        m_clear();
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  initial begin : stimulus
    int lat, cs_n, wr_n, base, base_rsp;
    bit got;
    logic [DW-1:0] rv;

    // Reset values while rst is still held.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lcd_cs", lcd_cs, 1'b1);
    check("rst_lcd_wr", lcd_wr, 1'b1);
    check("rst_lcd_rd", lcd_rd, 1'b1);
    check("rst_lcd_rs", lcd_rs, 1'b0);
    check("rst_lcd_db_out", lcd_db_out, 16'h0);
    check("rst_lcd_db_oe", lcd_db_oe, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single default write: done comes 4 cycles after the push.
    push(1'b0, 1'b0, 16'h0022, 16'h0, 1'b0);
    lat = -1; cs_n = 0; wr_n = 0;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (!lcd_cs) cs_n++;
      if (!lcd_wr) wr_n++;
      if (done) lat = k;
    end
    check("write_done_latency", lat, 32'd4);
    check("write_cs_low_cycles", cs_n, 32'd3);
    check("write_wr_low_cycles", wr_n, 32'd1);
    wait_idle();

    // Single read, then a write: rsp_data must hold the read word.
    push(1'b1, 1'b0, 16'h0000, 16'h5252, 1'b0);
    wait_idle();
    check("read_rsp_data", rsp_data, 16'h5252);
    push(1'b0, 1'b1, 16'h1111, 16'h0, 1'b0);
    wait_idle();
    check("rsp_data_holds", rsp_data, 16'h5252);

    // Burst of 6 writes with req_valid held high.
    saw_full = 1'b0;
    base = done_count;
    for (int i = 1; i <= 6; i++) push(1'b0, 1'b1, DW'(i), 16'h0, i < 6);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (done_count == base + 6) got = 1'b1;
    end
    check("burst_all_done", got, 1'b1);
    check("burst_busy_after_last", busy, 1'b0);
    check("burst_req_ready_dropped", saw_full, 1'b1);
    repeat (10) @(negedge clk);
    check("burst_done_pulses", done_count - base, 32'd6);

    // Mixed write/read alternation with varying RS.
    push(1'b0, 1'b1, 16'hA5A5, 16'h0, 1'b1);
    push(1'b1, 1'b0, 16'h0000, 16'h1234, 1'b1);
    push(1'b0, 1'b0, 16'hA5A5, 16'h0, 1'b1);
    push(1'b1, 1'b1, 16'h0000, 16'h1234, 1'b0);
    wait_idle();

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      rv = DW'($urandom);
      push(1'($urandom), 1'($urandom), DW'($urandom), rv, ($urandom_range(0, 2) != 0) && i < 39);
      if (!req_valid) repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();

    // Reset mid-read with more requests queued behind it.
    push(1'b1, 1'b1, 16'h0000, 16'hBEEF, 1'b0);
    push(1'b0, 1'b0, 16'h3333, 16'h0, 1'b0);
    push(1'b0, 1'b1, 16'h4444, 16'h0, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (!lcd_rd) got = 1'b1;
    end
    check("midread_rd_low_seen", got, 1'b1);
    base = done_count;
    base_rsp = rsp_count;
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_lcd_rd", lcd_rd, 1'b1);
    check("async_rst_lcd_cs", lcd_cs, 1'b1);
    check("async_rst_lcd_db_oe", lcd_db_oe, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_req_ready", req_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midread_no_done", done_count - base, 32'd0);
    check("midread_no_rsp_valid", rsp_count - base_rsp, 32'd0);
    check("midread_fifo_empty", busy, 1'b0);
    check("midread_rsp_data_reset", rsp_data, 16'h0);
    check("midread_db_out_reset", lcd_db_out, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd8080_bus_ctrl.md
# lcd8080_bus_ctrl

Parametrised 8080-style parallel LCD bus master for HX8352-class panels. It supports writes and reads with configurable setup, strobe and recovery widths. A small request FIFO accepts command/data words from upstream sequencers and decouples them from bus timing. It sits between the panel init/pixel-stream logic and the LCD pins, and provides read-back of panel registers (ID, status).

## Interface
- DATA_WIDTH, 16: LCD data bus width (8 or 16).
- FIFO_DEPTH, 4: request FIFO entries; power of 2, at least 2.
- SETUP_CYCLES, 1: cycles with CS low, RS and data valid before the strobe falls; range 1..15.
- WR_LOW_CYCLES, 1: lcd_wr low width; range 1..15.
- RD_LOW_CYCLES, 3: lcd_rd low width; range 1..15.
- RECOVER_CYCLES, 1: cycles with strobe high, CS low and data held after the strobe rises; range 1..15.
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full; a request is pushed when req_valid && req_ready.
- req_rs  in  1  1 = data, 0 = command (drives lcd_rs).
- req_read  in  1  1 = read transfer, 0 = write.
- req_data  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse: read data is valid.
- rsp_data  out  DATA_WIDTH  last captured read word; holds until the next read.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- done  out  1  one-cycle pulse per completed transfer.
- lcd_cs  out  1  chip select, active low.
- lcd_rs  out  1  register select.
- lcd_wr  out  1  write strobe, active low.
- lcd_rd  out  1  read strobe, active low.
- lcd_db_out  out  DATA_WIDTH  data driven to the pad.
- lcd_db_oe  out  1  pad output enable.
- lcd_db_in  in  DATA_WIDTH  data sampled from the pad.

## Operation
- The FIFO stores {read, rs, data}. req_ready = !full is combinational from registered pointers. A push while full cannot occur. A push and a pop in the same cycle are legal when not full.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop and go to SETUP.
  - SETUP: lasts SETUP_CYCLES, then goes to LOW.
  - LOW: lasts WR_LOW_CYCLES or RD_LOW_CYCLES, then goes to RECOVER.
  - RECOVER: lasts RECOVER_CYCLES, then goes to IDLE.
- A single 4-bit down-counter is loaded (N-1) on each state entry. The state advances when the counter is 0.
- On the pop edge, lcd_cs goes to 0, lcd_rs to the entry rs, and lcd_db_out to the entry data. lcd_db_oe goes to 1 for writes and stays 0 for reads. All of these hold through RECOVER.
- LOW state: the selected strobe (lcd_wr or lcd_rd) is 0. The other strobe stays 1. Both strobes are never low together.
- Read: lcd_db_in is registered into rsp_data on the edge that leaves LOW, i.e. the edge on which lcd_rd rises.
- Leaving RECOVER, on the edge entering IDLE:
  - lcd_cs goes to 1 and lcd_db_oe goes to 0.
  - done pulses for one cycle.
  - rsp_valid pulses for one cycle together with done, for reads only.
- lcd_db_out keeps its last value in IDLE.
- busy = (FIFO count != 0) || (state != IDLE), computed combinationally.

## Timing
- Reset values: lcd_cs=1, lcd_wr=1, lcd_rd=1, lcd_rs=0, lcd_db_out=0, lcd_db_oe=0, done=0, rsp_valid=0, rsp_data=0, busy=0, FIFO empty, req_ready=1.
- Assertion of rst mid-transfer returns all pins to their reset values immediately (asynchronously) and discards the FIFO. The aborted transfer raises no done or rsp_valid.
- With a request pushed at edge E and the FIFO previously empty:
  - pop and SETUP entry occur at E+1;
  - the strobe falls at E+1+SETUP_CYCLES;
  - the strobe rises after LOW cycles;
  - done is high in the cycle after E+1+SETUP+LOW+RECOVER.
- With defaults, a write pushed at E gives: CS low at E+1, WR low at E+2, WR high at E+3, IDLE and done at E+4.
- Each transfer occupies 1 + SETUP + LOW + RECOVER cycles, including one IDLE cycle between transfers. Back-to-back default writes run at 4 cycles per word.
- Ordering is strictly FIFO. Reads and writes interleave in request order.

## Test plan
- Reset: hold rst for 3 cycles, then check every output against its reset value, including req_ready=1 and busy=0.
- Single default write: push cmd 0x0022 with rs=0, then check CS low for 3 cycles, WR low for exactly 1 cycle, lcd_db_out=0x0022 with oe=1 across the WR rising edge, and a done pulse 4 cycles after the push.
- Single read (RD_LOW_CYCLES=3): drive lcd_db_in=0x5252 only during the last LOW cycle, then check rsp_data=0x5252, rsp_valid==done for 1 cycle, and lcd_db_oe=0 throughout.
- Burst: with FIFO_DEPTH=4, push 6 writes 0x0001..0x0006 with req_valid held high. Check that req_ready drops while full, that all 6 appear on the bus in order, that there are 6 done pulses, and that busy falls after the last one.
- Mixed: alternate write 0xA5A5 and read 0x1234 for 4 transfers. Check that the strobes never overlap, that RS follows each request, and that order is preserved.
- Reset mid-read: assert rst during the LOW state. Check that lcd_rd and lcd_cs return to 1 without waiting for a clock edge, that there is no rsp_valid, and that the FIFO is empty afterward.
